// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the harmonic_dds synthesiser:
//   - quad_e       : quadrant encoding of the top two phase-index bits
//   - sum_width()  : width of the signed per-frame accumulation register
//   - rom_entry()  : quarter-wave sine table value, evaluated at elaboration
// ---------------------------------------------------------------------------
package dds_pkg;

  // Top two bits of the phase index select the quadrant of the sine wave.
  typedef enum logic [1:0] {
    QUAD_RISE     = 2'b00,
    QUAD_FALL     = 2'b01,
    QUAD_NEG_RISE = 2'b10,
    QUAD_NEG_FALL = 2'b11
  } quad_e;

  localparam real PI = 3.14159265358979323846;

  // One bit of headroom per doubling of channels, plus the sign bit.
  function automatic int sum_width(input int out_w, input int channels);
    return out_w + $clog2(channels) + 1;
  endfunction

  // Samples are taken at the centre of each table step so the folded
  // quadrants join without repeating the peak or zero entries.
  function automatic int rom_entry(input int k, input int lut_aw, input int out_w);
    real amp;
    real ang;
    amp = real'((1 << (out_w - 1)) - 1);
    ang = (PI / 2.0) * (real'(k) + 0.5) / real'(1 << lut_aw);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// ---------------------------------------------------------------------------
// quarter_sine_rom
// Synchronous-read quarter-wave sine table, one clock of read latency.
// Ports:
//   clk   in   system clock
//   addr  in   LUT_AW-bit table address
//   data  out  OUT_W-1 bit unsigned magnitude, registered
// ---------------------------------------------------------------------------
module quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int OUT_W  = 10
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [OUT_W-2:0] rom_tbl [DEPTH];

  // Table contents are constants computed during elaboration.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int VAL = rom_entry(k, LUT_AW, OUT_W);
    assign rom_tbl[k] = (OUT_W-1)'(VAL);
  end

  always_ff @(posedge clk) begin
    data <= rom_tbl[addr];
  end

endmodule

// File: rtl/harmonic_dds.sv
// ---------------------------------------------------------------------------
// harmonic_dds
// Multi-channel DDS: CHANNELS phase accumulators share one quarter-wave ROM,
// serviced one per clock at the start of each SAMPLE_DIV-clock frame. The
// signed channel values are summed, averaged and output as offset binary.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   wr_en         in   frequency control word write strobe
//   wr_ch         in   channel addressed by the write
//   wr_fcw        in   phase increment per sample frame
//   ch_en         in   per-channel enable, sampled at frame start
//   phase_rst     in   request to clear all accumulators at next frame start
//   sample_out    out  offset-binary sample, held between strobes
//   sample_valid  out  one-clock strobe when sample_out updates
// ---------------------------------------------------------------------------
module harmonic_dds
  import dds_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 6,
  parameter int OUT_W      = 10,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    wr_ch,
  input  logic [PHASE_W-1:0]                                    wr_fcw,
  input  logic [CHANNELS-1:0]                                   ch_en,
  input  logic                                                  phase_rst,
  output logic [OUT_W-1:0]                                      sample_out,
  output logic                                                  sample_valid
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int SHIFT = $clog2(CHANNELS);
  localparam int SUM_W = sum_width(OUT_W, CHANNELS);
  localparam int IDX_W = LUT_AW + 2;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  logic [CNT_W-1:0]   cnt;
  logic               frame_start;
  logic               issue;
  logic               out_slot;

  logic [PHASE_W-1:0] fcw        [CHANNELS];
  logic [PHASE_W-1:0] shadow_fcw [CHANNELS];
  logic [PHASE_W-1:0] acc        [CHANNELS];
  logic [CHANNELS-1:0] en_q;
  logic               rst_pend;
  logic               clr_frame;

  logic [PHASE_W-1:0] cur_acc;
  logic [PHASE_W-1:0] cur_fcw;
  logic               cur_en;
  logic               cur_clear;
  logic [IDX_W-1:0]   phase_idx;
  quad_e              quad;
  logic [LUT_AW-1:0]  fold_addr;
  logic               fold_neg;

  logic               s1_valid, s1_neg, s1_zero;
  logic [LUT_AW-1:0]  s1_addr;
  logic               s2_valid, s2_neg, s2_zero;
  logic [OUT_W-2:0]   rom_data;
  logic signed [SUM_W-1:0] mag;
  logic signed [SUM_W-1:0] term;
  logic signed [SUM_W-1:0] sum;

  assign frame_start = (cnt == '0);
  assign issue       = (cnt < CNT_W'(CHANNELS));
  assign out_slot    = (cnt == CNT_W'(CHANNELS + 2));

  // Channel 0 is serviced in the frame-start cycle itself, before the
  // frame-start registers have captured their new values, so in that cycle
  // the live inputs are used instead of the registered copies.
  always_comb begin
    cur_acc = '0;
    cur_fcw = '0;
    cur_en  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cnt == CNT_W'(c)) begin
        cur_acc = acc[c];
        cur_fcw = frame_start ? fcw[c] : shadow_fcw[c];
        cur_en  = frame_start ? ch_en[c] : en_q[c];
      end
    end
    cur_clear = !cur_en || (frame_start ? (rst_pend || phase_rst) : clr_frame);
  end

  // Quadrant fold: odd quadrants read the table backwards, the lower half
  // of the wave negates the magnitude.
  always_comb begin
    phase_idx = cur_acc[PHASE_W-1 -: IDX_W];
    quad      = quad_e'(phase_idx[IDX_W-1 -: 2]);
    fold_addr = phase_idx[LUT_AW-1:0];
    fold_neg  = 1'b0;
    case (quad)
      QUAD_RISE:     begin fold_addr =  phase_idx[LUT_AW-1:0]; fold_neg = 1'b0; end
      QUAD_FALL:     begin fold_addr = ~phase_idx[LUT_AW-1:0]; fold_neg = 1'b0; end
      QUAD_NEG_RISE: begin fold_addr =  phase_idx[LUT_AW-1:0]; fold_neg = 1'b1; end
      QUAD_NEG_FALL: begin fold_addr = ~phase_idx[LUT_AW-1:0]; fold_neg = 1'b1; end
      default:       begin fold_addr =  phase_idx[LUT_AW-1:0]; fold_neg = 1'b0; end
    endcase
  end

  // Frame counter, control word storage, frame-start snapshots and the
  // accumulator update for whichever channel owns the current slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      en_q      <= '0;
      rst_pend  <= 1'b0;
      clr_frame <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        fcw[c]        <= '0;
        shadow_fcw[c] <= '0;
        acc[c]        <= '0;
      end
    end else begin
      cnt <= (cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt + 1'b1;

      if (frame_start) begin
        en_q      <= ch_en;
        clr_frame <= rst_pend || phase_rst;
        rst_pend  <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          shadow_fcw[c] <= fcw[c];
        end
      end else if (phase_rst) begin
        rst_pend <= 1'b1;
      end

      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en && (wr_ch == CH_W'(c))) begin
          fcw[c] <= wr_fcw;
        end
        if (issue && (cnt == CNT_W'(c))) begin
          acc[c] <= cur_clear ? '0 : acc[c] + cur_fcw;
        end
      end
    end
  end

  quarter_sine_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk  (clk),
    .addr (s1_addr),
    .data (rom_data)
  );

  always_comb begin
    mag  = signed'(SUM_W'(rom_data));
    term = s2_zero ? '0 : (s2_neg ? -mag : mag);
  end

  // Three-stage channel pipeline feeding the frame sum, then the averaged
  // offset-binary output once the last channel has been added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_neg       <= 1'b0;
      s1_zero      <= 1'b0;
      s1_addr      <= '0;
      s2_valid     <= 1'b0;
      s2_neg       <= 1'b0;
      s2_zero      <= 1'b0;
      sum          <= '0;
      sample_out   <= MID;
      sample_valid <= 1'b0;
    end else begin
      s1_valid <= issue;
      s1_neg   <= fold_neg;
      s1_zero  <= cur_clear;
      s1_addr  <= fold_addr;

      s2_valid <= s1_valid;
      s2_neg   <= s1_neg;
      s2_zero  <= s1_zero;

      if (frame_start) begin
        sum <= '0;
      end else if (s2_valid) begin
        sum <= sum + term;
      end

      sample_valid <= out_slot;
      if (out_slot) begin
        sample_out <= OUT_W'(sum >>> SHIFT) + MID;
      end
    end
  end

endmodule

// File: tb/tb_harmonic_dds.sv
// ---------------------------------------------------------------------------
// tb_harmonic_dds
// Directed self-checking bench for harmonic_dds at PHASE_W=24, LUT_AW=6,
// OUT_W=10, CHANNELS=4, with a short 16-clock frame. Expected samples are
// hand-computed from ROM[0]=6 and ROM[63]=511.
// ---------------------------------------------------------------------------
module tb_harmonic_dds;

  localparam int CHANNELS   = 4;
  localparam int PHASE_W    = 24;
  localparam int LUT_AW     = 6;
  localparam int OUT_W      = 10;
  localparam int SAMPLE_DIV = 16;
  localparam int LATENCY    = CHANNELS + 3;
  localparam int WAIT_LIMIT = 2 * SAMPLE_DIV;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en;
  logic [1:0]         wr_ch;
  logic [PHASE_W-1:0] wr_fcw;
  logic [CHANNELS-1:0] ch_en;
  logic               phase_rst;
  logic [OUT_W-1:0]   sample_out;
  logic               sample_valid;

  int checkCount = 0;
  int passCount  = 0;

  harmonic_dds #(
    .CHANNELS   (CHANNELS),
    .PHASE_W    (PHASE_W),
    .LUT_AW     (LUT_AW),
    .OUT_W      (OUT_W),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_fcw       (wr_fcw),
    .ch_en        (ch_en),
    .phase_rst    (phase_rst),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [CHANNELS-1:0] en);
    ch_en = en;
  endtask

  task automatic writeFcw(input logic [1:0] ch, input logic [PHASE_W-1:0] val);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_fcw = val;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic pulsePhaseRst();
    phase_rst = 1'b1;
    @(negedge clk);
    phase_rst = 1'b0;
  endtask

  // Called at the negedge of a strobe cycle; lands on the negedge of the
  // next frame-start cycle.
  task automatic gotoFrameStart();
    repeat (SAMPLE_DIV - LATENCY) @(negedge clk);
  endtask

  task automatic waitValid(output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    while (!found && cycles < WAIT_LIMIT) begin
      @(negedge clk);
      cycles++;
      if (sample_valid) found = 1'b1;
    end
  endtask

  task automatic getSample(input string tag, input int expected);
    int cycles;
    bit found;
    waitValid(cycles, found);
    checkOutput({tag, "_strobe"}, 32'(found), 32'd1);
    checkOutput(tag, 32'(sample_out), 32'(expected));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    bit found;
    int validSeen;
    int singleSeq[4];
    int quadSeq[4];
    int writeSeq[5];
    logic [7:0] modelPhase;

    singleSeq = '{513, 639, 510, 384};
    quadSeq   = '{512, 518, 1023, 506};
    writeSeq  = '{513, 639, 384, 639, 384};

    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_ch     = '0;
    wr_fcw    = '0;
    ch_en     = '0;
    phase_rst = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_sample", 32'(sample_out), 32'd512);
    checkOutput("reset_valid", 32'(sample_valid), 32'd0);

    // Release in a frame-start cycle; first strobe LATENCY clocks later
    rst_n = 1'b1;
    waitValid(cycles, found);
    checkOutput("first_latency", 32'(cycles), 32'(LATENCY));
    checkOutput("first_sample_idle", 32'(sample_out), 32'd512);
    @(negedge clk);
    checkOutput("strobe_width", 32'(sample_valid), 32'd0);

    // Single channel at a quarter-cycle step
    writeFcw(2'd0, 24'h400000);
    applyStimulus(4'b0001);
    for (int i = 0; i < 8; i++)
      getSample($sformatf("single_%0d", i), singleSeq[i % 4]);

    // Write lands one cycle after frame start: old step for this frame
    gotoFrameStart();
    @(negedge clk);
    writeFcw(2'd0, 24'h800000);
    for (int i = 0; i < 5; i++)
      getSample($sformatf("write_timing_%0d", i), writeSeq[i]);

    // Drop enable for one frame; re-enabled channel restarts at phase 0
    writeFcw(2'd0, 24'h400000);
    getSample("pre_disable", 639);
    gotoFrameStart();
    applyStimulus(4'b0000);
    @(negedge clk);
    applyStimulus(4'b0001);
    getSample("disabled_frame", 512);
    getSample("reenable_0", 513);
    getSample("reenable_1", 639);

    // phase_rst on a single channel
    pulsePhaseRst();
    getSample("prst_single_clear", 512);
    getSample("prst_single_0", 513);
    getSample("prst_single_1", 639);

    // Four channels in phase
    writeFcw(2'd1, 24'h400000);
    writeFcw(2'd2, 24'h400000);
    writeFcw(2'd3, 24'h400000);
    applyStimulus(4'b1111);
    pulsePhaseRst();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) getSample($sformatf("quad_%0d", i), quadSeq[i]);
      else if (i == 4) getSample("quad_min", 1);
      else getSample("quad_repeat", 518);
    end

    // phase_rst clears all four channels
    pulsePhaseRst();
    getSample("prst_all_clear", 512);
    getSample("prst_all_restart", 518);

    // Reset mid-frame: immediate reset values, no strobe while held
    gotoFrameStart();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_sample", 32'(sample_out), 32'd512);
    checkOutput("midreset_valid", 32'(sample_valid), 32'd0);
    validSeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sample_valid) validSeen++;
    end
    checkOutput("midreset_no_strobe", 32'(validSeen), 32'd0);
    rst_n = 1'b1;
    waitValid(cycles, found);
    checkOutput("post_reset_latency", 32'(cycles), 32'(LATENCY));
    checkOutput("post_reset_sample", 32'(sample_out), 32'd518);

    // Wrap: step of -64 phase index per frame, checked against a model
    writeFcw(2'd0, 24'hC00000);
    applyStimulus(4'b0001);
    pulsePhaseRst();
    getSample("wrap_clear", 512);
    modelPhase = 8'd0;
    for (int f = 0; f < 1000; f++) begin
      getSample($sformatf("wrap_%0d", f), singleSeq[modelPhase[7:6]]);
      modelPhase = modelPhase + 8'd192;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
